// File: rtl/mispred_recovery.sv
// mispred_recovery: latches the oldest mispredicted branch, flushes the back end, then redirects fetch.
module mispred_recovery #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [75:0]      IN_branch,
  input  logic             IN_redirReady,
  output logic             OUT_flush,
  output logic [6:0]       OUT_flushSqN,
  output logic [6:0]       OUT_flushLoadSqN,
  output logic [6:0]       OUT_flushStoreSqN,
  output logic             OUT_fullFlush,
  output logic             OUT_redirValid,
  output logic [31:0]      OUT_redirPC,
  output logic [15:0]      OUT_redirHistory,
  output logic [4:0]       OUT_redirFetchID,
  output logic             OUT_busy,
  output logic [CNT_W-1:0] OUT_mispredCnt
);
  localparam int FW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;
  state_t state;
  logic [FW-1:0] fcnt;
  logic [6:0] diff;
  logic accept;
  // Negative 7-bit difference means the incoming branch is older, wrap-around included.
  assign diff = IN_branch[43:37] - OUT_flushSqN;
  assign accept = IN_branch[0] && (state == IDLE || diff[6]);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fcnt <= '0;
      OUT_flush <= 1'b0;
      OUT_redirValid <= 1'b0;
      OUT_busy <= 1'b0;
      OUT_flushSqN <= '0;
      OUT_flushLoadSqN <= '0;
      OUT_flushStoreSqN <= '0;
      OUT_fullFlush <= 1'b0;
      OUT_redirPC <= '0;
      OUT_redirHistory <= '0;
      OUT_redirFetchID <= '0;
      OUT_mispredCnt <= '0;
    end else if (accept) begin
      state <= FLUSH;
      fcnt <= FW'(FLUSH_CYCLES - 1);
      OUT_flush <= 1'b1;
      OUT_redirValid <= 1'b0;
      OUT_busy <= 1'b1;
      OUT_redirPC <= IN_branch[75:44];
      OUT_flushSqN <= IN_branch[43:37];
      OUT_flushLoadSqN <= IN_branch[36:30];
      OUT_flushStoreSqN <= IN_branch[29:23];
      OUT_fullFlush <= IN_branch[22];
      OUT_redirFetchID <= IN_branch[21:17];
      OUT_redirHistory <= IN_branch[16:1];
      if (~&OUT_mispredCnt) OUT_mispredCnt <= OUT_mispredCnt + 1'b1;
    end else if (state == FLUSH) begin
      if (fcnt == '0) begin
        state <= REDIRECT;
        OUT_flush <= 1'b0;
        OUT_redirValid <= 1'b1;
      end else begin
        fcnt <= fcnt - 1'b1;
      end
    end else if (state == REDIRECT && IN_redirReady) begin
      state <= IDLE;
      OUT_redirValid <= 1'b0;
      OUT_busy <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mispred_recovery.sv
// tb_mispred_recovery: directed and random scenarios against a phase-counting reference model.
module tb_mispred_recovery;
  localparam int FC = 2;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0;
  logic rst;
  logic [75:0] IN_branch;
  logic IN_redirReady;
  logic OUT_flush, OUT_fullFlush, OUT_redirValid, OUT_busy;
  logic [6:0] OUT_flushSqN, OUT_flushLoadSqN, OUT_flushStoreSqN;
  logic [31:0] OUT_redirPC;
  logic [15:0] OUT_redirHistory;
  logic [4:0] OUT_redirFetchID;
  logic [CW-1:0] OUT_mispredCnt;
  int total = 0;
  int bad = 0;
  int m_fl, m_cnt;
  bit m_rd, m_full;
  logic [6:0] m_sq, m_lq, m_ssq;
  logic [31:0] m_pc;
  logic [15:0] m_h;
  logic [4:0] m_f;

  mispred_recovery #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .IN_branch(IN_branch), .IN_redirReady(IN_redirReady),
    .OUT_flush(OUT_flush), .OUT_flushSqN(OUT_flushSqN), .OUT_flushLoadSqN(OUT_flushLoadSqN),
    .OUT_flushStoreSqN(OUT_flushStoreSqN), .OUT_fullFlush(OUT_fullFlush),
    .OUT_redirValid(OUT_redirValid), .OUT_redirPC(OUT_redirPC), .OUT_redirHistory(OUT_redirHistory),
    .OUT_redirFetchID(OUT_redirFetchID), .OUT_busy(OUT_busy), .OUT_mispredCnt(OUT_mispredCnt)
  );

  always #5 clk = ~clk;

  function automatic logic [75:0] mk(input bit v, input logic [6:0] sq, input logic [31:0] pc,
                                     input logic [4:0] fid, input logic [15:0] h);
    return {pc, sq, 7'(sq + 7'd3), 7'(sq + 7'd5), sq[0], fid, h, v};
  endfunction

  function automatic logic [80:0] got();
    return {OUT_flush, OUT_flushSqN, OUT_flushLoadSqN, OUT_flushStoreSqN, OUT_fullFlush,
            OUT_redirValid, OUT_redirPC, OUT_redirHistory, OUT_redirFetchID, OUT_busy, OUT_mispredCnt};
  endfunction

  function automatic logic [80:0] expv();
    return {m_fl > 0, m_sq, m_lq, m_ssq, m_full, m_rd, m_pc, m_h, m_f, (m_fl > 0) || m_rd, CW'(m_cnt)};
  endfunction

  // Model: m_fl counts remaining flush cycles, m_rd marks a pending redirect.
  task automatic model_step(input logic r, input logic [75:0] b, input logic rdy);
    int d;
    bit idle, acc;
    idle = m_fl == 0 && !m_rd;
    d = (int'(b[43:37]) - int'(m_sq) + 128) % 128;
    acc = b[0] && (idle || d >= 64);
    if (r) begin
      m_fl = 0; m_rd = 0; m_cnt = 0; m_sq = 0; m_lq = 0; m_ssq = 0;
      m_full = 0; m_pc = 0; m_h = 0; m_f = 0;
    end else if (acc) begin
      m_pc = b[75:44]; m_sq = b[43:37]; m_lq = b[36:30]; m_ssq = b[29:23];
      m_full = b[22]; m_f = b[21:17]; m_h = b[16:1];
      m_cnt = m_cnt < CMAX ? m_cnt + 1 : CMAX;
      m_fl = FC; m_rd = 0;
    end else if (m_fl > 0) begin
      m_fl--;
      if (m_fl == 0) m_rd = 1;
    end else if (m_rd && rdy) begin
      m_rd = 0;
    end
  endtask

  task automatic cyc(input logic r, input logic [75:0] b, input logic rdy);
    rst = r; IN_branch = b; IN_redirReady = rdy;
    @(posedge clk);
    model_step(r, b, rdy);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1, mk(1, 7'($urandom), $urandom, 5'($urandom), 16'($urandom)), 1);
      total++;
      if (got() !== 81'd0) begin
        bad++;
        $display("FAIL reset got=%h want=0", got());
      end
    end
  endtask

  task automatic test_basic();
    cyc(0, mk(1, 7'd10, 32'h1000, 5'd3, 16'hbeef), 0);
    total++;
    if (OUT_flush !== 1 || OUT_flushSqN !== 7'd10 || OUT_redirValid !== 0) begin
      bad++;
      $display("FAIL basic_t1 flush=%b sqn=%0d rv=%b want 1/10/0", OUT_flush, OUT_flushSqN, OUT_redirValid);
    end
    cyc(0, '0, 1);
    total++;
    if (OUT_flush !== 1 || OUT_redirValid !== 0) begin
      bad++;
      $display("FAIL basic_t2 flush=%b rv=%b want 1/0", OUT_flush, OUT_redirValid);
    end
    cyc(0, '0, 1);
    total++;
    if (OUT_flush !== 0 || OUT_redirValid !== 1 || OUT_redirPC !== 32'h1000 || OUT_redirFetchID !== 5'd3) begin
      bad++;
      $display("FAIL basic_t3 flush=%b rv=%b pc=%h fid=%0d want 0/1/1000/3",
               OUT_flush, OUT_redirValid, OUT_redirPC, OUT_redirFetchID);
    end
    cyc(0, '0, 1);
    total++;
    if (OUT_busy !== 0 || OUT_redirValid !== 0 || OUT_mispredCnt !== CW'(1) || OUT_redirPC !== 32'h1000) begin
      bad++;
      $display("FAIL basic_t4 busy=%b rv=%b cnt=%0d pc=%h want 0/0/1/1000",
               OUT_busy, OUT_redirValid, OUT_mispredCnt, OUT_redirPC);
    end
    total++;
    if (got() !== expv()) begin
      bad++;
      $display("FAIL basic_model got=%h want=%h", got(), expv());
    end
  endtask

  task automatic test_preempt();
    cyc(0, mk(1, 7'd10, 32'h2000, 5'd1, 16'h1), 0);
    cyc(0, mk(1, 7'd12, 32'h3000, 5'd2, 16'h2), 0);
    total++;
    if (OUT_flushSqN !== 7'd10 || OUT_flush !== 1 || got() !== expv()) begin
      bad++;
      $display("FAIL preempt_young sqn=%0d flush=%b want 10/1", OUT_flushSqN, OUT_flush);
    end
    cyc(0, mk(1, 7'd5, 32'h5000, 5'd7, 16'h5), 0);
    total++;
    if (OUT_flushSqN !== 7'd5 || OUT_flush !== 1) begin
      bad++;
      $display("FAIL preempt_old sqn=%0d flush=%b want 5/1", OUT_flushSqN, OUT_flush);
    end
    cyc(0, '0, 0);
    total++;
    if (OUT_flush !== 1) begin
      bad++;
      $display("FAIL preempt_window flush=%b want 1", OUT_flush);
    end
    cyc(0, '0, 1);
    total++;
    if (OUT_redirValid !== 1 || OUT_redirPC !== 32'h5000 || OUT_mispredCnt !== CW'(3)) begin
      bad++;
      $display("FAIL preempt_redir rv=%b pc=%h cnt=%0d want 1/5000/3", OUT_redirValid, OUT_redirPC, OUT_mispredCnt);
    end
    cyc(0, '0, 1);
    total++;
    if (got() !== expv() || OUT_busy !== 0) begin
      bad++;
      $display("FAIL preempt_done got=%h want=%h", got(), expv());
    end
  endtask

  task automatic test_wrap();
    cyc(0, mk(1, 7'h7e, 32'h100, 5'd1, 16'h0), 0);
    cyc(0, mk(1, 7'h01, 32'h200, 5'd2, 16'h0), 0);
    total++;
    if (OUT_flushSqN !== 7'h7e || got() !== expv()) begin
      bad++;
      $display("FAIL wrap_young sqn=%h want 7e", OUT_flushSqN);
    end
    for (int i = 0; i < 3; i++) cyc(0, '0, 1);
    cyc(0, mk(1, 7'h02, 32'h300, 5'd3, 16'h0), 0);
    cyc(0, mk(1, 7'h7f, 32'h400, 5'd4, 16'h0), 0);
    total++;
    if (OUT_flushSqN !== 7'h7f || OUT_flush !== 1 || got() !== expv()) begin
      bad++;
      $display("FAIL wrap_old sqn=%h flush=%b want 7f/1", OUT_flushSqN, OUT_flush);
    end
    for (int i = 0; i < 4; i++) cyc(0, '0, 1);
  endtask

  task automatic test_hold();
    logic [52:0] snap;
    cyc(0, mk(1, 7'd40, 32'hcafe0000, 5'd9, 16'h1234), 0);
    cyc(0, '0, 0);
    cyc(0, '0, 0);
    snap = {OUT_redirPC, OUT_redirHistory, OUT_redirFetchID};
    for (int i = 0; i < 5; i++) begin
      cyc(0, '0, 0);
      total++;
      if (OUT_redirValid !== 1 || {OUT_redirPC, OUT_redirHistory, OUT_redirFetchID} !== {32'hcafe0000, 16'h1234, 5'd9}
          || got() !== expv()) begin
        bad++;
        $display("FAIL hold_%0d rv=%b fields=%h want 1/%h", i, OUT_redirValid,
                 {OUT_redirPC, OUT_redirHistory, OUT_redirFetchID}, snap);
      end
    end
    cyc(0, '0, 1);
    total++;
    if (OUT_busy !== 0 || OUT_redirValid !== 0) begin
      bad++;
      $display("FAIL hold_release busy=%b rv=%b want 0/0", OUT_busy, OUT_redirValid);
    end
  endtask

  task automatic test_back_to_back();
    cyc(0, mk(1, 7'd60, 32'h6000, 5'd6, 16'h6), 0);
    cyc(0, '0, 0);
    cyc(0, '0, 0);
    cyc(0, mk(1, 7'd50, 32'h7000, 5'd8, 16'h8), 1);
    total++;
    if (OUT_flush !== 1 || OUT_redirValid !== 0 || OUT_flushSqN !== 7'd50 || got() !== expv()) begin
      bad++;
      $display("FAIL b2b flush=%b rv=%b sqn=%0d want 1/0/50", OUT_flush, OUT_redirValid, OUT_flushSqN);
    end
    cyc(0, '0, 0);
    cyc(1, '0, 1);
    total++;
    if (got() !== 81'd0) begin
      bad++;
      $display("FAIL rst_mid got=%h want=0", got());
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, '0, 1);
      total++;
      if (OUT_redirValid !== 0 || OUT_busy !== 0) begin
        bad++;
        $display("FAIL rst_noredir rv=%b busy=%b want 0/0", OUT_redirValid, OUT_busy);
      end
    end
  endtask

  task automatic test_saturate();
    cyc(1, '0, 0);
    for (int i = 1; i <= 10; i++) begin
      cyc(0, mk(1, 7'(100 - i), 32'(i), 5'(i), 16'(i)), 0);
      total++;
      if (OUT_mispredCnt !== CW'(i < CMAX ? i : CMAX)) begin
        bad++;
        $display("FAIL sat_%0d cnt=%0d want %0d", i, OUT_mispredCnt, i < CMAX ? i : CMAX);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 49) == 0, mk($urandom_range(0, 2) == 0, 7'($urandom), $urandom,
          5'($urandom), 16'($urandom)), 1'($urandom));
      total++;
      if (got() !== expv()) begin
        bad++;
        $display("FAIL random_%0d got=%h want=%h", i, got(), expv());
      end
    end
  endtask

  initial begin
    rst = 1; IN_branch = '0; IN_redirReady = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_preempt();
    test_wrap();
    test_hold();
    test_back_to_back();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mispred_recovery.md
Name: mispred_recovery

Overview:
- Consumer end of the selected-branch bus: takes the single oldest-mispredict record each cycle and runs pipeline recovery.
- Latches the record, holds a flush window over the back end, then redirects fetch with a valid/ready handshake.
- Drives the mispredict-flush indication and flush sequence number back to the selector, so younger branches are filtered while recovery is in progress.
- Sits between the branch selector and the fetch/rename/load-store queues.

Parameters:
- FLUSH_CYCLES, 2, number of cycles OUT_flush is asserted per recovery; must be >= 1.
- CNT_W, 32, width of the saturating mispredict counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- IN_branch  in  76  selected branch record: [0] valid, [16:1] history, [21:17] fetchID, [22] fullFlush, [29:23] storeSqN, [36:30] loadSqN, [43:37] sqN, [75:44] dstPC
- IN_redirReady  in  1  fetch accepts redirect
- OUT_flush  out  1  back-end flush active (feeds selector's mispredict-flush input)
- OUT_flushSqN  out  7  sqN of the latched branch; younger ops are squashed
- OUT_flushLoadSqN  out  7  latched loadSqN
- OUT_flushStoreSqN  out  7  latched storeSqN
- OUT_fullFlush  out  1  latched fullFlush bit, valid while OUT_flush=1
- OUT_redirValid  out  1  redirect request to fetch
- OUT_redirPC  out  32  latched dstPC
- OUT_redirHistory  out  16  latched history
- OUT_redirFetchID  out  5  latched fetchID
- OUT_busy  out  1  state != IDLE
- OUT_mispredCnt  out  CNT_W  accepted-branch count, saturating

Behaviour:
- Reset: state IDLE, all outputs 0, latched record 0, counter 0. Reset mid-recovery aborts immediately; no redirect is issued.
- States: IDLE, FLUSH, REDIRECT. OUT_flush=1 exactly in FLUSH. OUT_redirValid=1 exactly in REDIRECT.
- Accept rule:
  - In IDLE, IN_branch[0]=1 accepts.
  - In FLUSH/REDIRECT, accept only if the incoming sqN is strictly older: $signed(in.sqN - cur.sqN) < 0 on the 7-bit difference, so wrap-around is handled.
  - Equal or younger records are ignored.
- On accept at edge t:
  - Latch all fields.
  - Increment the counter (stays at all-ones once saturated).
  - State = FLUSH at t+1 with the flush counter loaded to FLUSH_CYCLES-1.
- FLUSH: decrement the counter each cycle. When it is 0 and there is no accept, go to REDIRECT next cycle. OUT_flush is therefore high for exactly FLUSH_CYCLES consecutive cycles per uninterrupted recovery.
- Preemption in FLUSH: accept reloads the counter and latch, so the window restarts in full. OUT_flush stays high with no gap. OUT_flushSqN updates the cycle after accept.
- REDIRECT:
  - Outputs are held stable while valid && !ready.
  - On valid && ready, go to IDLE next cycle.
- Simultaneous redirect handshake and older accept in REDIRECT: the handshake counts as completed (fetch took the old PC), then state = FLUSH with the new record. Accept wins over the IDLE transition.
- Record outputs (flushSqN, PC, etc.) hold their last latched value in IDLE. Only valid/flush/busy drop.
- Single always_ff for state, counters and latch; outputs are registered, with no combinational path from IN_branch to any output.

Test Plan:
- Reset, then branch {valid, sqN=10, dstPC=0x1000, fetchID=3} at t0 -> OUT_flush=1 at t0+1 and t0+2, OUT_flushSqN=10. OUT_redirValid=1 at t0+3 with PC 0x1000. With ready=1, OUT_busy=0 at t0+4. OUT_mispredCnt=1.
- In FLUSH with sqN=10, inject sqN=12 -> ignored, counter unchanged. Inject sqN=5 -> latched, flush window restarts for 2 full cycles, redirect PC is sqN=5's dstPC, count=2.
- Wrap-around: current sqN=0x7E, inject sqN=0x01 (younger) -> ignored. Current sqN=0x02, inject sqN=0x7F (older) -> accepted.
- Hold ready=0 for 5 cycles in REDIRECT -> OUT_redirValid and the PC/history/fetchID fields remain constant. Ready=1 -> IDLE next cycle.
- In REDIRECT, ready=1 together with an older branch in the same cycle -> handshake completes, state=FLUSH next cycle, OUT_flushSqN = new sqN. Assert rst mid-FLUSH -> all outputs 0 next cycle, no redirect.
- Force OUT_mispredCnt to all-ones -> further accepts keep it saturated.
